// File: rtl/wisc_pkg.sv
// Shared WISC types and constants for the fetch stage.
package wisc_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0]         OP_HLT    = 4'hF;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus2;
    logic               valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus2: '0, valid: 1'b0};

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (clear) begin
      count <= 16'h0000;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// WISC instruction fetch: PC, imem drive, IF/ID register, branch redirect, HLT stop.
// Optional perf counters built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
);

  fetch_state_t    state, state_nx;
  logic [PC_W-1:0] pc, pc_nx, pc_plus2;
  if_id_t          if_id, if_id_nx;
  logic            unused_target_bit0;

  assign unused_target_bit0 = branch_target[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= '0;
      if_id <= IF_ID_BUBBLE;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if_id <= if_id_nx;
    end
  end

  // Priority in RUN: branch > stall > HLT > sequential fetch.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if_id_nx = if_id;
    pc_plus2 = pc + PC_W'(2);
    case (state)
      RUN: begin
        if (branch_taken) begin
          pc_nx    = {branch_target[15:1], 1'b0};
          if_id_nx = IF_ID_BUBBLE;
        end else if (!stall) begin
          if_id_nx = '{instr: imem_data, pc_plus2: pc_plus2, valid: 1'b1};
          if (imem_data[15:12] == OP_HLT) begin
            state_nx = HALTED;
          end else begin
            pc_nx = pc_plus2;
          end
        end
      end
      HALTED: begin
        if (!stall) begin
          if_id_nx = IF_ID_BUBBLE;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign imem_addr      = pc;
  assign imem_rd_en     = (state == RUN) && !rst;
  assign if_id_instr    = if_id.instr;
  assign if_id_pc_plus2 = if_id.pc_plus2;
  assign if_id_valid    = if_id.valid;
  assign halted         = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, stall_inc;

  assign fetch_inc = (state == RUN) && !branch_taken && !stall;
  assign stall_inc = (state == RUN) && !branch_taken && stall;

  sat_counter16 u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .en    (fetch_inc),
    .count (fetch_count)
  );

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .en    (stall_inc),
    .count (stall_count)
  );
`else
  assign fetch_count = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed vectors push expectations, monitor checks each cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic [15:0] stall_count;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
    logic [15:0] addr;
    logic        halted;
    logic        rd_en;
    logic [15:0] fc;
    logic [15:0] sc;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] fexp = 16'h0000;
  logic [15:0] sexp = 16'h0000;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Called at a negedge: apply one cycle of inputs, queue the post-edge expectation.
  task automatic step(input logic s, input logic b, input logic [15:0] tgt,
                      input logic [15:0] mem, input logic [15:0] ei, input logic [15:0] ep,
                      input logic ev, input logic [15:0] ea, input logic eh,
                      input bit incf, input bit incs);
    exp_t e;
    stall         = s;
    branch_taken  = b;
    branch_target = tgt;
    imem_data     = mem;
    if (incf && CNT_EN) fexp = fexp + 16'd1;
    if (incs && CNT_EN) sexp = sexp + 16'd1;
    e.instr  = ei;
    e.pc2    = ep;
    e.valid  = ev;
    e.addr   = ea;
    e.halted = eh;
    e.rd_en  = !eh;
    e.fc     = fexp;
    e.sc     = sexp;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_values(string tag);
    chk({tag, "_addr"},  imem_addr, 16'h0000);
    chk({tag, "_rd_en"}, 16'(imem_rd_en), 16'h0000);
    chk({tag, "_instr"}, if_id_instr, 16'h0000);
    chk({tag, "_pc2"},   if_id_pc_plus2, 16'h0000);
    chk({tag, "_valid"}, 16'(if_id_valid), 16'h0000);
    chk({tag, "_halt"},  16'(halted), 16'h0000);
    chk({tag, "_fcnt"},  fetch_count, 16'h0000);
    chk({tag, "_scnt"},  stall_count, 16'h0000);
  endtask

  // Monitor: the DUT presents a new IF/ID/PC state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("instr", if_id_instr, e.instr);
        chk("pc_plus2", if_id_pc_plus2, e.pc2);
        chk("valid", 16'(if_id_valid), 16'(e.valid));
        chk("imem_addr", imem_addr, e.addr);
        chk("halted", 16'(halted), 16'(e.halted));
        chk("imem_rd_en", 16'(imem_rd_en), 16'(e.rd_en));
        chk("fetch_count", fetch_count, e.fc);
        chk("stall_count", stall_count, e.sc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;
    //   stall br  tgt       imem      instr     pc2       v     addr      h     f  s
    step(1'b0, 1'b0, 16'h0000, 16'h1234, 16'h1234, 16'h0002, 1'b1, 16'h0002, 1'b0, 1, 0);
    step(1'b0, 1'b0, 16'h0000, 16'h0567, 16'h0567, 16'h0004, 1'b1, 16'h0004, 1'b0, 1, 0);
    step(1'b0, 1'b0, 16'h0000, 16'h1111, 16'h1111, 16'h0006, 1'b1, 16'h0006, 1'b0, 1, 0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 16'h0000, 16'h2222, 16'h1111, 16'h0006, 1'b1, 16'h0006, 1'b0, 0, 1);
    step(1'b0, 1'b0, 16'h0000, 16'h2222, 16'h2222, 16'h0008, 1'b1, 16'h0008, 1'b0, 1, 0);
    // Taken branch at PC 8: odd target forced even, wrong-path fetch becomes a bubble.
    step(1'b0, 1'b1, 16'h0041, 16'h3333, 16'h0000, 16'h0000, 1'b0, 16'h0040, 1'b0, 0, 0);
    step(1'b0, 1'b0, 16'h0000, 16'h4444, 16'h4444, 16'h0042, 1'b1, 16'h0042, 1'b0, 1, 0);
    // HLT squashed by a simultaneous branch.
    step(1'b0, 1'b1, 16'h0010, 16'hF000, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b0, 0, 0);
    step(1'b0, 1'b0, 16'h0000, 16'hF000, 16'hF000, 16'h0012, 1'b1, 16'h0010, 1'b1, 1, 0);
    // HALTED: stall holds IF/ID without counting; then bubble, branch ignored.
    step(1'b1, 1'b0, 16'h0000, 16'h5555, 16'hF000, 16'h0012, 1'b1, 16'h0010, 1'b1, 0, 0);
    step(1'b0, 1'b1, 16'h0100, 16'h5555, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b1, 0, 0);
    step(1'b0, 1'b0, 16'h0000, 16'h6666, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b1, 0, 0);

    // Asynchronous reset while HALTED, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("async_rst");
    fexp = 16'h0000;
    sexp = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0000, 16'hABCD, 16'hABCD, 16'h0002, 1'b1, 16'h0002, 1'b0, 1, 0);
    // Redirect to the top of memory and check PC+2 wrap.
    step(1'b0, 1'b1, 16'hFFFF, 16'h7777, 16'h0000, 16'h0000, 1'b0, 16'hFFFE, 1'b0, 0, 0);
    step(1'b0, 1'b0, 16'h0000, 16'h5555, 16'h5555, 16'h0000, 1'b1, 16'h0000, 1'b0, 1, 0);
    // Branch wins over stall; no stall cycle counted.
    step(1'b1, 1'b1, 16'h0020, 16'h8888, 16'h0000, 16'h0000, 1'b0, 16'h0020, 1'b0, 0, 0);
    step(1'b0, 1'b0, 16'h0000, 16'h9999, 16'h9999, 16'h0022, 1'b1, 16'h0022, 1'b0, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
